// File: rtl/risc16_sequencer.sv
// risc16_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM.
// Optional macro SEQ_PERF_CNT_EN adds instr_count/cycle_count.
module risc16_sequencer #(
  parameter int unsigned MAX_WAIT = 8
`ifdef SEQ_PERF_CNT_EN
  , parameter int unsigned CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [3:0] opcode,
  input  logic       mem_ack,
  output logic       ir_load,
  output logic       pc_en,
  output logic       jump,
  output logic       beq,
  output logic       bne,
  output logic       alu_src,
  output logic       reg_des,
  output logic       mem_reg,
  output logic [1:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       illegal,
  output logic       bus_err,
  output logic       halted
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
`endif
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC,
    S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    K_LW, K_SW, K_ALU,
    K_BR, K_JMP, K_ILL
  } kind_e;

  typedef struct packed {
    logic       jump;
    logic       beq;
    logic       bne;
    logic       alu_src;
    logic       reg_des;
    logic       mem_reg;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT - 1);

  state_e     state_q, state_d;
  kind_e      kind_q, kind_d, dec_kind;
  ctrl_t      ctrl_q, ctrl_d, dec_ctrl;
  logic [7:0] wait_q, wait_d;
  logic       bus_err_q, bus_err_d;
  logic       ir_load_s;

  always_comb begin
    dec_ctrl = '0;
    dec_kind = K_ILL;
    unique case (1'b1)
      opcode == 4'b0000: begin
        dec_kind = K_LW;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.mem_reg = 1'b1;
        dec_ctrl.alu_op  = 2'b10;
      end
      opcode == 4'b0001: begin
        dec_kind = K_SW;
        dec_ctrl.alu_src = 1'b1;
        dec_ctrl.alu_op  = 2'b10;
      end
      opcode inside {[4'b0010:4'b1001]}: begin
        dec_kind = K_ALU;
        dec_ctrl.reg_des = 1'b1;
      end
      opcode == 4'b1011: begin
        dec_kind = K_BR;
        dec_ctrl.beq    = 1'b1;
        dec_ctrl.alu_op = 2'b01;
      end
      opcode == 4'b1100: begin
        dec_kind = K_BR;
        dec_ctrl.bne    = 1'b1;
        dec_ctrl.alu_op = 2'b01;
      end
      opcode == 4'b1101: begin
        dec_kind = K_JMP;
        dec_ctrl.jump = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    kind_d    = kind_q;
    ctrl_d    = ctrl_q;
    wait_d    = wait_q;
    bus_err_d = bus_err_q;
    ir_load_s = 1'b0;
    pc_en     = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ir_load_s = 1'b1;
        kind_d    = dec_kind;
        ctrl_d    = dec_ctrl;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        if (kind_q == K_ILL) begin
          illegal = 1'b1;
          pc_en   = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (kind_q)
          K_BR, K_JMP: pc_en = 1'b1;
          K_LW, K_SW: begin
            state_d = S_MEM;
            wait_d  = '0;
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        mem_read  = (kind_q == K_LW);
        mem_write = (kind_q == K_SW);
        // ack on the final allowed cycle still counts
        if (mem_ack) begin
          if (kind_q == K_SW) pc_en = 1'b1;
          else state_d = S_WB;
        end else if (wait_q == LIMIT) begin
          bus_err_d = 1'b1;
          ctrl_d    = '0;
          state_d   = S_HALT;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_en     = 1'b1;
      end
      S_HALT: begin
        if (run && !bus_err_q) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (pc_en) begin
      state_d = run ? S_FETCH : S_HALT;
      ctrl_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      kind_q    <= K_ILL;
      ctrl_q    <= '0;
      wait_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      kind_q    <= kind_d;
      ctrl_q    <= ctrl_d;
      wait_q    <= wait_d;
      bus_err_q <= bus_err_d;
    end
  end

  // keep the strobe quiet while reset holds the FSM in FETCH
  assign ir_load = ir_load_s & rst_n;
  assign jump    = ctrl_q.jump;
  assign beq     = ctrl_q.beq;
  assign bne     = ctrl_q.bne;
  assign alu_src = ctrl_q.alu_src;
  assign reg_des = ctrl_q.reg_des;
  assign mem_reg = ctrl_q.mem_reg;
  assign alu_op  = ctrl_q.alu_op;
  assign bus_err = bus_err_q;
  assign halted  = (state_q == S_HALT);

`ifdef SEQ_PERF_CNT_EN
  logic [CNT_W-1:0] icnt_q, ccnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt_q <= '0;
      ccnt_q <= '0;
    end else begin
      if (state_q != S_HALT) ccnt_q <= ccnt_q + CNT_W'(1);
      if (pc_en) icnt_q <= icnt_q + CNT_W'(1);
    end
  end

  assign instr_count = icnt_q;
  assign cycle_count = ccnt_q;
`endif

endmodule

// File: tb/tb_risc16_sequencer.sv
// Directed self-checking bench for risc16_sequencer.
// Cycle n = the n-th clock window after rst_n release.
module tb_risc16_sequencer;

  logic       clk, rst_n, run, mem_ack;
  logic [3:0] opcode;
  logic       ir_load, pc_en, jump, beq, bne;
  logic       alu_src, reg_des, mem_reg;
  logic [1:0] alu_op;
  logic       mem_read, mem_write, reg_write;
  logic       illegal, bus_err, halted;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] instr_count, cycle_count;
`endif

  int passed = 0;
  int total  = 0;

  risc16_sequencer #(.MAX_WAIT(8)) dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .opcode(opcode), .mem_ack(mem_ack),
    .ir_load(ir_load), .pc_en(pc_en),
    .jump(jump), .beq(beq), .bne(bne),
    .alu_src(alu_src), .reg_des(reg_des),
    .mem_reg(mem_reg), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .illegal(illegal),
    .bus_err(bus_err), .halted(halted)
`ifdef SEQ_PERF_CNT_EN
    , .instr_count(instr_count),
    .cycle_count(cycle_count)
`endif
  );

  // {ir_load,pc_en,reg_write,mem_read,mem_write,illegal,halted,bus_err}
  logic [7:0] strb;
  // {jump,beq,bne,alu_src,reg_des,mem_reg,alu_op}
  logic [7:0] ctl;
  assign strb = {ir_load, pc_en, reg_write, mem_read,
                 mem_write, illegal, halted, bus_err};
  assign ctl  = {jump, beq, bne, alu_src,
                 reg_des, mem_reg, alu_op};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic start(input logic r);
    rst_n   = 1'b0;
    run     = r;
    mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; run = 1'b1;
    opcode = 4'b0010; mem_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (strb !== 8'h00)
      $display("FAIL reset_strb got %h exp 00", strb);
    else passed++;
    total++;
    if (ctl !== 8'h00)
      $display("FAIL reset_ctl got %h exp 00", ctl);
    else passed++;
`ifdef SEQ_PERF_CNT_EN
    total++;
    if ({instr_count, cycle_count} !== 64'd0)
      $display("FAIL reset_cnt got %0d/%0d exp 0/0",
               instr_count, cycle_count);
    else passed++;
`endif
  endtask

  task automatic test_rtype;
    logic [7:0] es, ec;
    opcode = 4'b0010;
    start(1'b1);
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) begin
        @(negedge clk); opcode = 4'b1111; #1;
      end
      case (c)
        1:       begin es = 8'h80; ec = 8'h00; end
        2, 3:    begin es = 8'h00; ec = 8'h08; end
        4:       begin es = 8'h60; ec = 8'h08; end
        default: begin es = 8'h80; ec = 8'h00; end
      endcase
      total++;
      if (strb !== es)
        $display("FAIL rtype_strb c%0d got %h exp %h", c, strb, es);
      else passed++;
      total++;
      if (ctl !== ec)
        $display("FAIL rtype_ctl c%0d got %h exp %h", c, ctl, ec);
      else passed++;
    end
  endtask

  task automatic test_lw;
    logic [7:0] es, ec;
    opcode = 4'b0000;
    start(1'b1);
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) begin
        @(negedge clk);
        mem_ack = (c == 3) || (c == 7);
        #1;
      end
      case (c)
        1:       begin es = 8'h80; ec = 8'h00; end
        2, 3:    begin es = 8'h00; ec = 8'h16; end
        4, 5, 6, 7: begin es = 8'h10; ec = 8'h16; end
        8:       begin es = 8'h60; ec = 8'h16; end
        default: begin es = 8'h80; ec = 8'h00; end
      endcase
      total++;
      if (strb !== es)
        $display("FAIL lw_strb c%0d got %h exp %h", c, strb, es);
      else passed++;
      total++;
      if (ctl !== ec)
        $display("FAIL lw_ctl c%0d got %h exp %h", c, ctl, ec);
      else passed++;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_sw_limit;
    logic [7:0] es;
    opcode = 4'b0001;
    start(1'b1);
    for (int c = 1; c <= 16; c++) begin
      if (c > 1) begin
        @(negedge clk);
        if (c >= 13) run = c[0];
        #1;
      end
      case (c)
        1:       es = 8'h80;
        2, 3:    es = 8'h00;
        4, 5, 6, 7, 8, 9, 10, 11: es = 8'h08;
        default: es = 8'h03;
      endcase
      total++;
      if (strb !== es)
        $display("FAIL sw_to_strb c%0d got %h exp %h", c, strb, es);
      else passed++;
      if (c == 3) begin
        total++;
        if (ctl !== 8'h12)
          $display("FAIL sw_ctl got %h exp 12", ctl);
        else passed++;
      end
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (strb !== 8'h00)
      $display("FAIL sw_to_clear got %h exp 00", strb);
    else passed++;
    // ack on the last allowed wait cycle succeeds
    start(1'b1);
    for (int c = 2; c <= 12; c++) begin
      @(negedge clk);
      mem_ack = (c == 11);
      #1;
      if (c >= 11) begin
        es = (c == 11) ? 8'h48 : 8'h80;
        total++;
        if (strb !== es)
          $display("FAIL sw_lim_strb c%0d got %h exp %h",
                   c, strb, es);
        else passed++;
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_branch;
    logic [7:0] es, ec;
    opcode = 4'b1011;
    start(1'b1);
    for (int c = 1; c <= 7; c++) begin
      if (c > 1) begin
        @(negedge clk); opcode = 4'b1101; #1;
      end
      case (c)
        2:       begin es = 8'h00; ec = 8'h41; end
        3:       begin es = 8'h40; ec = 8'h41; end
        5:       begin es = 8'h00; ec = 8'h80; end
        6:       begin es = 8'h40; ec = 8'h80; end
        default: begin es = 8'h80; ec = 8'h00; end
      endcase
      total++;
      if (strb !== es)
        $display("FAIL br_strb c%0d got %h exp %h", c, strb, es);
      else passed++;
      total++;
      if (ctl !== ec)
        $display("FAIL br_ctl c%0d got %h exp %h", c, ctl, ec);
      else passed++;
    end
  endtask

  task automatic test_illegal;
    logic [7:0] es, ec;
    opcode = 4'b1111;
    start(1'b1);
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) begin
        @(negedge clk);
        opcode  = 4'b0000;
        mem_ack = (c == 6);
        if (c == 5) run = 1'b0;
        if (c == 10) run = 1'b1;
        #1;
      end
      case (c)
        2:       begin es = 8'h44; ec = 8'h00; end
        4, 5:    begin es = 8'h00; ec = 8'h16; end
        6:       begin es = 8'h10; ec = 8'h16; end
        7:       begin es = 8'h60; ec = 8'h16; end
        8, 9, 10: begin es = 8'h02; ec = 8'h00; end
        default: begin es = 8'h80; ec = 8'h00; end
      endcase
      total++;
      if (strb !== es)
        $display("FAIL ill_strb c%0d got %h exp %h", c, strb, es);
      else passed++;
      total++;
      if (ctl !== ec)
        $display("FAIL ill_ctl c%0d got %h exp %h", c, ctl, ec);
      else passed++;
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_run_low_start;
    logic [7:0] es;
    opcode = 4'b0101;
    start(1'b0);
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin
        @(negedge clk); #1;
      end
      case (c)
        1:       es = 8'h80;
        2, 3:    es = 8'h00;
        4:       es = 8'h60;
        default: es = 8'h02;
      endcase
      total++;
      if (strb !== es)
        $display("FAIL runlow_strb c%0d got %h exp %h",
                 c, strb, es);
      else passed++;
    end
  endtask

  task automatic test_reset_mid;
    opcode = 4'b0000;
    start(1'b1);
    repeat (4) @(negedge clk);
    #1;
    total++;
    if (strb !== 8'h10)
      $display("FAIL rmid_pre got %h exp 10", strb);
    else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({strb, ctl} !== 16'h0000)
      $display("FAIL rmid_async got %h exp 0000", {strb, ctl});
    else passed++;
`ifdef SEQ_PERF_CNT_EN
    total++;
    if ({instr_count, cycle_count} !== 64'd0)
      $display("FAIL rmid_cnt got %0d/%0d exp 0/0",
               instr_count, cycle_count);
    else passed++;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (strb !== 8'h80)
      $display("FAIL rmid_restart got %h exp 80", strb);
    else passed++;
  endtask

`ifdef SEQ_PERF_CNT_EN
  task automatic test_perf;
    opcode = 4'b0011;
    start(1'b1);
    repeat (12) @(negedge clk);
    #1;
    total++;
    if (instr_count !== 32'd3)
      $display("FAIL perf_instr got %0d exp 3", instr_count);
    else passed++;
    total++;
    if (cycle_count !== 32'd12)
      $display("FAIL perf_cycle got %0d exp 12", cycle_count);
    else passed++;
  endtask
`endif

  initial begin
    rst_n = 1'b0; run = 1'b1;
    opcode = 4'b0000; mem_ack = 1'b0;
    test_reset;
    test_rtype;
    test_lw;
    test_sw_limit;
    test_branch;
    test_illegal;
    test_run_low_start;
    test_reset_mid;
`ifdef SEQ_PERF_CNT_EN
    test_perf;
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
